bamse_irq_ctrl: RTL and testbench

Interrupt front-end for the bamse PicoBlaze3 subsystem. Sits directly upstream of the processor's interrupt/interrupt_ack pair and beside its I/O port bus. It synchronises and debounces the raw push-button inputs, latches rising edges as pending requests, and applies a software mask. It drives a single level interrupt that is held until acknowledged and re-armed by software. Pending, mask and level registers are exposed on the INPUT/OUTPUT port space.

---
 rtl/bamse_irq_ctrl.sv | 151 +++++++++++++++
 tb/tb_bamse_irq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bamse_irq_ctrl.sv
// Interrupt front-end for the bamse PicoBlaze3 subsystem: button sync/debounce,
// rising-edge pending latch, software mask, and a held level interrupt.
module bamse_irq_ctrl #(
    parameter int          N_SRC           = 3,
    parameter int          DEBOUNCE_CYCLES = 32000,
    parameter logic [7:0]  BASE_ADDR       = 8'hE0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] btn_in,
    input  logic [7:0]       port_id,
    input  logic             write_strobe,
    input  logic             read_strobe,
    input  logic [7:0]       out_port,
    output logic [7:0]       in_port,
    output logic             interrupt,
    input  logic             interrupt_ack,
    output logic [N_SRC-1:0] btn_level
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     ADDR_PEND = BASE_ADDR;
    localparam logic [7:0]     ADDR_MASK = BASE_ADDR + 8'd1;
    localparam logic [7:0]     ADDR_LVL  = BASE_ADDR + 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    logic [N_SRC-1:0] sync1_r, sync2_r;
    logic [N_SRC-1:0] level_s, level_d_r, rise_s;
    logic [N_SRC-1:0] pend_r, mask_r, clr_s;
    logic             wr_pend_s, wr_mask_s, req_s;
    logic [7:0]       in_port_r;
    logic             interrupt_r;
    state_t           state_r, state_nx_s;
    logic             unused_s;

    // Reads have no side effects and only the low N_SRC data bits are stored.
    assign unused_s = ^{read_strobe, out_port};

    // Two-stage synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_deb
        logic [CW-1:0] cnt_r;
        logic          lvl_r;

        // A new level is accepted only after it has differed for DEBOUNCE_CYCLES samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
                lvl_r <= 1'b0;
            end else if (sync2_r[i] == lvl_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r <= '0;
                lvl_r <= sync2_r[i];
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end

        assign level_s[i] = lvl_r;
    end

    assign rise_s    = level_s & ~level_d_r;
    assign wr_pend_s = write_strobe && (port_id == ADDR_PEND);
    assign wr_mask_s = write_strobe && (port_id == ADDR_MASK);
    assign clr_s     = wr_pend_s ? out_port[N_SRC-1:0] : {N_SRC{1'b0}};
    assign req_s     = |(pend_r & mask_r);

    // Pending (write-1-to-clear, new edges win) and mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d_r <= '0;
            pend_r    <= '0;
            mask_r    <= '1;
        end else begin
            level_d_r <= level_s;
            pend_r    <= (pend_r & ~clr_s) | rise_s;
            if (wr_mask_s) begin
                mask_r <= out_port[N_SRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Registered read mux for the mapped port addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_port_r <= 8'h00;
        end else begin
            case (port_id)
                ADDR_PEND: in_port_r <= 8'(pend_r);
                ADDR_MASK: in_port_r <= 8'(mask_r);
                ADDR_LVL:  in_port_r <= 8'(level_s);
                default:   in_port_r <= 8'h00;
            endcase
        end
    end

    // Interrupt state register; the output is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            interrupt_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            interrupt_r <= (state_nx_s == ST_REQ);
        end
    end

    // Next-state logic; an ack takes priority over a concurrent full mask-off.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) state_nx_s = ST_REQ;
                else       state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (interrupt_ack) state_nx_s = ST_SERV;
                else if (!req_s)   state_nx_s = ST_IDLE;
                else               state_nx_s = ST_REQ;
            end
            ST_SERV: begin
                if (wr_pend_s) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_SERV;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    assign in_port   = in_port_r;
    assign interrupt = interrupt_r;
    assign btn_level = level_s;

endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// Directed scoreboard bench for bamse_irq_ctrl with a short debounce window.
module tb_bamse_irq_ctrl;

    localparam int         N_SRC = 3;
    localparam int         DEB   = 8;
    localparam logic [7:0] A_P   = 8'hE0;
    localparam logic [7:0] A_M   = 8'hE1;
    localparam logic [7:0] A_L   = 8'hE2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_SRC-1:0] btn_in;
    logic [7:0]       port_id;
    logic             write_strobe;
    logic             read_strobe;
    logic [7:0]       out_port;
    logic [7:0]       in_port;
    logic             interrupt;
    logic             interrupt_ack;
    logic [N_SRC-1:0] btn_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t sb_q[$];

    bamse_irq_ctrl #(.N_SRC(N_SRC), .DEBOUNCE_CYCLES(DEB), .BASE_ADDR(A_P)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .port_id(port_id),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .out_port(out_port),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_int(input string tag, input logic exp);
        expect_val(tag, {7'd0, exp});
        check_val({7'd0, interrupt});
    endtask

    task automatic chk_lvl(input string tag, input logic [N_SRC-1:0] exp);
        expect_val(tag, {5'd0, exp});
        check_val({5'd0, btn_level});
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        port_id = addr;
        expect_val(tag, exp);
        tick(1);
        check_val(in_port);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0;
        out_port     = 8'h00;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_in = '0; port_id = 8'h00; write_strobe = 1'b0;
        read_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
        tick(3);
        chk_int("rst_int", 1'b0);
        chk_lvl("rst_lvl", 3'b000);
        expect_val("rst_inport", 8'h00);
        check_val(in_port);
        rst = 1'b0;
        rd("rst_mask", A_M, 8'h07);

        // short glitch is rejected
        btn_in = 3'b001; tick(5); btn_in = 3'b000; tick(20);
        chk_lvl("glitch_lvl", 3'b000);
        chk_int("glitch_int", 1'b0);
        rd("glitch_pend", A_P, 8'h00);

        // held press: level at edge 10, pend at 11, interrupt at 12
        btn_in = 3'b001;
        tick(9);
        chk_lvl("lvl_early", 3'b000);
        tick(1);
        chk_lvl("lvl_accept", 3'b001);
        chk_int("int_at_lvl", 1'b0);
        tick(1);
        chk_int("int_at_pend", 1'b0);
        expect_val("pend_first", 8'h01);
        tick(1);
        check_val(in_port);
        chk_int("int_req", 1'b1);
        btn_in = 3'b000;

        // ack then re-arm
        ack();
        chk_int("ack_drop", 1'b0);
        tick(3);
        chk_int("ack_hold", 1'b0);
        wr(A_P, 8'h01);
        chk_int("rearm_int", 1'b0);
        rd("rearm_pend", A_P, 8'h00);
        tick(12);

        // second source queued while in service
        btn_in = 3'b001;
        tick(12);
        chk_int("q_req", 1'b1);
        btn_in = 3'b011;
        ack();
        tick(11);
        expect_val("q_pend", 8'h03);
        check_val(in_port);
        chk_int("q_serv_int", 1'b0);
        wr(A_P, 8'h01);
        chk_int("q_idle_int", 1'b0);
        tick(1);
        chk_int("q_rereq", 1'b1);
        expect_val("q_pend2", 8'h02);
        check_val(in_port);
        ack();
        wr(A_P, 8'h02);
        btn_in = 3'b000;
        tick(15);
        chk_int("q_clean", 1'b0);

        // masked source, then unmask
        wr(A_M, 8'h06);
        port_id = A_P;
        btn_in = 3'b001;
        tick(13);
        expect_val("mask_pend", 8'h01);
        check_val(in_port);
        chk_int("mask_int", 1'b0);
        wr(A_M, 8'h07);
        chk_int("unmask_e", 1'b0);
        tick(1);
        chk_int("unmask_req", 1'b1);

        // readback and read-only LEVEL
        rd("rb_mask", A_M, 8'h07);
        rd("rb_lvl", A_L, 8'h01);
        rd("rb_unmapped", 8'h55, 8'h00);
        wr(A_L, 8'hFF);
        rd("lvl_ro", A_L, 8'h01);
        rd("rb_mask2", A_M, 8'h07);
        rd("rb_pend", A_P, 8'h01);
        ack();
        wr(A_P, 8'h01);
        btn_in = 3'b000;
        tick(15);
        chk_int("rb_clean", 1'b0);

        // clear of bit 2 in the same cycle its edge is latched
        port_id = A_P;
        btn_in = 3'b100;
        tick(10);
        chk_lvl("col_lvl", 3'b100);
        out_port = 8'h04; write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0; out_port = 8'h00;
        expect_val("col_pend", 8'h04);
        tick(1);
        check_val(in_port);
        chk_int("col_req", 1'b1);

        // asynchronous reset mid-request, button still held
        rst = 1'b1;
        #1;
        chk_int("arst_int", 1'b0);
        chk_lvl("arst_lvl", 3'b000);
        expect_val("arst_inport", 8'h00);
        check_val(in_port);
        tick(2);
        rst = 1'b0;
        rd("arst_mask", A_M, 8'h07);
        tick(8);
        chk_lvl("held_early", 3'b000);
        tick(1);
        chk_lvl("held_accept", 3'b100);
        tick(2);
        chk_int("held_req", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
